fetch_unit: RTL

Instruction fetch stage that owns the program counter and feeds decode through a small prefetch FIFO. Sits between the word-addressed instruction memory and the decoder/controller. Issues one memory request at a time with a req/ack handshake, buffers fetched words with their PC, and honours branch redirects by flushing and restarting fetch at the target.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one-at-a-time imem req/ack, prefetch FIFO.
// Optional FETCH_BYPASS_EN forwards an ack straight to decode when empty.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     drop_pc_q, drop_pc_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [AW:0]     count_q, count_nxt;
  logic            fifo_valid;
  logic            push, pop;
  logic            byp, byp_take;

  assign fifo_valid = (count_q != '0);
  // a redirect flushes the FIFO, so a same-cycle pop is moot
  assign pop = fifo_valid & instr_ready & ~redirect;

`ifdef FETCH_BYPASS_EN
  assign byp = (state_q == REQ) & imem_ack & ~redirect & ~fifo_valid;
  assign byp_take = byp & instr_ready;
`else
  assign byp = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign push = (state_q == REQ) & imem_ack & ~redirect & ~byp_take;
  assign count_nxt = count_q + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_pc_d  = drop_pc_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = REQ;
        end else if (count_q < FULL) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (!imem_ack) begin
            drop_pc_d = fetch_pc_q;
            state_d   = DROP;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd1;
          state_d    = (count_nxt < FULL) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_pc_q  <= drop_pc_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= imem_rdata;
          pc_q[wr_ptr_q]   <= fetch_pc_q;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_nxt;
      end
    end
  end

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = (state_q == DROP) ? drop_pc_q : fetch_pc_q;
  assign instr_valid = fifo_valid | byp;
  assign instr_out   = byp ? imem_rdata : data_q[rd_ptr_q];
  assign instr_pc    = byp ? fetch_pc_q : pc_q[rd_ptr_q];

endmodule
